// File: rtl/usb_pkg.sv
// Shared USB definitions: token, handshake and data PID codes plus the IN endpoint FSM state type.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package usb_pkg;

    // Token type codes carried on trn_type.
    localparam logic [1:0] TOK_OUT   = 2'b00;
    localparam logic [1:0] TOK_IN    = 2'b10;
    localparam logic [1:0] TOK_SETUP = 2'b11;

    // Handshake codes.
    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NYET  = 2'b01;
    localparam logic [1:0] HSK_NAK   = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;

    // Data PID codes.
    localparam logic [1:0] PID_DATA0 = 2'b00;
    localparam logic [1:0] PID_DATA1 = 2'b10;

    // One-hot endpoint states.
    typedef enum logic [4:0] {
        ST_FILL     = 5'b00001,
        ST_READY    = 5'b00010,
        ST_SEND     = 5'b00100,
        ST_WAIT_ACK = 5'b01000,
        ST_NAK      = 5'b10000
    } ep_state_t;

    // Data PID for the current data toggle.
    function automatic logic [1:0] data_pid(input logic tog);
        return tog ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_ep_buffer.sv
// Packet storage: simple dual-port RAM, DEPTH x 8, one write port, one registered read port.
// Latency: read data appears one clock after rd_addr is presented; writes land on the clock edge.
// Backpressure: none; caller owns address sequencing.
// Ports: clk/rst_n; wr_en, wr_addr, wr_data (write port); rd_addr, rd_data (registered read port).
module usb_ep_buffer #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_bulk_in_ep.sv
// Bulk IN endpoint: buffers one packet from an AXI-Stream byte source and answers IN tokens with DATA0/1, NAK or STALL.
// Latency: data_start/valid one clock after a matching IN token; one byte per clock while tx_trn_data_ready=1.
// Backpressure: s_axis_tready high only while filling; transmit stalls on tx_trn_data_ready=0; handshakes held until tx_trn_hsk_sended.
// Ports: clk/rst_n; s_axis_* payload input; trn_* token input; rx_trn_hsk_* host handshake;
//        tx_trn_send_hsk/hsk_type/hsk_sended handshake request; tx_trn_data_* packet transmit stream;
//        toggle_clear forces DATA0 next; ep_busy flags an unacknowledged packet.
// Build option: define USB_EP_HALT_EN to add the ep_halt input and STALL responses.
module usb_bulk_in_ep
    import usb_pkg::*;
#(
    parameter int ENDPOINT        = 1,
    parameter int MAX_PACKET_SIZE = 512,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef USB_EP_HALT_EN
    input  logic       ep_halt,
`endif
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic [7:0] s_axis_tdata,
    input  logic       trn_start,
    input  logic [1:0] trn_type,
    input  logic [3:0] trn_endpoint,
    input  logic       rx_trn_hsk_received,
    input  logic [1:0] rx_trn_hsk_type,
    output logic       tx_trn_send_hsk,
    output logic [1:0] tx_trn_hsk_type,
    input  logic       tx_trn_hsk_sended,
    output logic       tx_trn_data_start,
    output logic [1:0] tx_trn_data_type,
    output logic [7:0] tx_trn_data,
    output logic       tx_trn_data_valid,
    input  logic       tx_trn_data_ready,
    output logic       tx_trn_data_last,
    input  logic       toggle_clear,
    output logic       ep_busy
);

    localparam int AW = (MAX_PACKET_SIZE > 1) ? $clog2(MAX_PACKET_SIZE) : 1;
    localparam int LW = $clog2(MAX_PACKET_SIZE + 1);
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] MPS_L = LW'(MAX_PACKET_SIZE);

    ep_state_t     state;
    logic          toggle;
    logic          out_en;     // keeps tready low until the first clock after reset release
    logic [LW-1:0] wr_ptr;     // bytes written so far
    logic [LW-1:0] length;     // nonzero only once a complete packet is buffered
    logic [AW-1:0] rd_ptr;     // index of the byte currently presented
    logic [TW-1:0] tmo_cnt;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    logic in_match, wr_fire, wr_done, rd_fire, rd_last, ack_rx;
    logic halt_on, halt_rel;

`ifdef USB_EP_HALT_EN
    logic halt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= ep_halt;
        end
    end
    assign halt_on  = ep_halt;
    assign halt_rel = halt_q && !ep_halt;
`else
    assign halt_on  = 1'b0;
    assign halt_rel = 1'b0;
`endif

    assign in_match = trn_start && (trn_type == TOK_IN) && (trn_endpoint == 4'(ENDPOINT));
    assign s_axis_tready = out_en && (state == ST_FILL);
    assign wr_fire  = s_axis_tvalid && s_axis_tready;
    assign wr_done  = wr_fire && (s_axis_tlast || (wr_ptr == MPS_L - LW'(1)));
    assign rd_fire  = tx_trn_data_valid && tx_trn_data_ready;
    assign rd_last  = (LW'(rd_ptr) == length - LW'(1));
    assign ack_rx   = rx_trn_hsk_received && (rx_trn_hsk_type == HSK_ACK);

    assign tx_trn_data_last = tx_trn_data_valid && rd_last;
    assign tx_trn_data      = tx_trn_data_valid ? rd_data : 8'h00;
    assign ep_busy = (state inside {ST_READY, ST_SEND, ST_WAIT_ACK}) ||
                     ((state == ST_NAK) && (wr_ptr != '0));

    // The RAM is addressed with the pointer value of the next cycle, so the
    // registered read lands exactly when that byte must be on tx_trn_data.
    // Outside SEND the address parks at 0, pre-loading the first byte.
    always_comb begin
        rd_addr = '0;
        if (state == ST_SEND) begin
            rd_addr = rd_fire ? (rd_ptr + AW'(1)) : rd_ptr;
        end
    end

    usb_ep_buffer #(
        .DEPTH (MAX_PACKET_SIZE),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_FILL;
            out_en            <= 1'b0;
            toggle            <= 1'b0;
            wr_ptr            <= '0;
            length            <= '0;
            rd_ptr            <= '0;
            tmo_cnt           <= '0;
            tx_trn_send_hsk   <= 1'b0;
            tx_trn_hsk_type   <= 2'b00;
            tx_trn_data_start <= 1'b0;
            tx_trn_data_valid <= 1'b0;
            tx_trn_data_type  <= 2'b00;
        end else begin
            out_en            <= 1'b1;
            tx_trn_data_start <= 1'b0;
            unique case (state)
                ST_FILL: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + LW'(1);
                    end
                    if (wr_done) begin
                        length <= wr_ptr + LW'(1);
                    end
                    // A byte completing the packet alongside the token is
                    // kept; the NAK exit then lands in READY via length.
                    if (in_match) begin
                        state           <= ST_NAK;
                        tx_trn_send_hsk <= 1'b1;
                        tx_trn_hsk_type <= halt_on ? HSK_STALL : HSK_NAK;
                    end else if (wr_done) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (in_match) begin
                        if (halt_on) begin
                            state           <= ST_NAK;
                            tx_trn_send_hsk <= 1'b1;
                            tx_trn_hsk_type <= HSK_STALL;
                        end else begin
                            state             <= ST_SEND;
                            rd_ptr            <= '0;
                            tx_trn_data_start <= 1'b1;
                            tx_trn_data_valid <= 1'b1;
                            tx_trn_data_type  <= data_pid(toggle);
                        end
                    end
                end
                ST_SEND: begin
                    // Tokens are not looked at here: a packet always completes.
                    if (rd_fire) begin
                        if (rd_last) begin
                            state             <= ST_WAIT_ACK;
                            rd_ptr            <= '0;
                            tmo_cnt           <= '0;
                            tx_trn_data_valid <= 1'b0;
                            tx_trn_data_type  <= 2'b00;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_rx) begin
                        state  <= ST_FILL;
                        length <= '0;
                        wr_ptr <= '0;
                    end else if (in_match || (tmo_cnt == TW'(ACK_TIMEOUT))) begin
                        state <= ST_READY;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_NAK: begin
                    // Shared by NAK and STALL; returns to wherever the buffer says.
                    if (tx_trn_hsk_sended) begin
                        tx_trn_send_hsk <= 1'b0;
                        tx_trn_hsk_type <= 2'b00;
                        state           <= (length != '0) ? ST_READY : ST_FILL;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase

            // Clear beats a simultaneous ACK flip.
            if (toggle_clear || halt_rel) begin
                toggle <= 1'b0;
            end else if ((state == ST_WAIT_ACK) && ack_rx) begin
                toggle <= ~toggle;
            end
        end
    end

endmodule

// File: tb/tb_usb_bulk_in_ep.sv
module tb_usb_bulk_in_ep;

    localparam int MPS = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
`ifdef USB_EP_HALT_EN
    logic       ep_halt = 1'b0;
`endif
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       trn_start = 1'b0;
    logic [1:0] trn_type = 2'b00;
    logic [3:0] trn_endpoint = 4'h0;
    logic       rx_trn_hsk_received = 1'b0;
    logic [1:0] rx_trn_hsk_type = 2'b00;
    logic       tx_trn_send_hsk;
    logic [1:0] tx_trn_hsk_type;
    logic       tx_trn_hsk_sended = 1'b0;
    logic       tx_trn_data_start;
    logic [1:0] tx_trn_data_type;
    logic [7:0] tx_trn_data;
    logic       tx_trn_data_valid;
    logic       tx_trn_data_ready = 1'b0;
    logic       tx_trn_data_last;
    logic       toggle_clear = 1'b0;
    logic       ep_busy;

    always #5 clk = ~clk;

    usb_bulk_in_ep #(
        .ENDPOINT        (1),
        .MAX_PACKET_SIZE (MPS),
        .ACK_TIMEOUT     (255)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
`ifdef USB_EP_HALT_EN
        .ep_halt             (ep_halt),
`endif
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tdata        (s_axis_tdata),
        .trn_start           (trn_start),
        .trn_type            (trn_type),
        .trn_endpoint        (trn_endpoint),
        .rx_trn_hsk_received (rx_trn_hsk_received),
        .rx_trn_hsk_type     (rx_trn_hsk_type),
        .tx_trn_send_hsk     (tx_trn_send_hsk),
        .tx_trn_hsk_type     (tx_trn_hsk_type),
        .tx_trn_hsk_sended   (tx_trn_hsk_sended),
        .tx_trn_data_start   (tx_trn_data_start),
        .tx_trn_data_type    (tx_trn_data_type),
        .tx_trn_data         (tx_trn_data),
        .tx_trn_data_valid   (tx_trn_data_valid),
        .tx_trn_data_ready   (tx_trn_data_ready),
        .tx_trn_data_last    (tx_trn_data_last),
        .toggle_clear        (toggle_clear),
        .ep_busy             (ep_busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the host-visible data toggle and the bytes the next packet must carry.
    bit         m_toggle = 1'b0;
    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];

    // Capture of one received packet.
    logic [7:0] rx_q[$];
    int         rx_starts, rx_last_idx, rx_bubbles;
    logic [1:0] rx_pid;
    bit         rx_timeout;

    function automatic logic [1:0] exp_pid();
        return m_toggle ? 2'b10 : 2'b00;
    endfunction

    function automatic int data_errors();
        int n = 0;
        if (rx_timeout || rx_q.size() != exp_q.size()) return 1000000;
        foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic make_packet(input int n);
        pkt_q = {};
        for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
        exp_q = pkt_q;
    endtask

    // Streams pkt_q into the endpoint; tready is stable from negedge to the next posedge.
    task automatic push_packet(input bit use_last, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < pkt_q.size()) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                continue;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pkt_q[i];
            s_axis_tlast  = use_last && (i == pkt_q.size() - 1);
            if (s_axis_tready) begin
                i++;
            end else if (++guard > 200) begin
                checks++; failures++;
                $display("FAIL push_timeout: tready stuck at %0b after %0d of %0d bytes, want 1", s_axis_tready, i, pkt_q.size());
                break;
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_token(input logic [1:0] t, input logic [3:0] ep);
        @(negedge clk);
        trn_start = 1'b1; trn_type = t; trn_endpoint = ep;
        @(negedge clk);
        trn_start = 1'b0; trn_type = 2'b00; trn_endpoint = 4'h0;
    endtask

    task automatic in_receive(input bit throttle);
        int cyc = 0;
        rx_q = {}; rx_starts = 0; rx_last_idx = -1; rx_bubbles = 0; rx_pid = 2'bxx; rx_timeout = 0;
        send_token(2'b10, 4'd1);
        forever begin
            tx_trn_data_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tx_trn_data_valid) begin
                if (tx_trn_data_start) begin rx_starts++; rx_pid = tx_trn_data_type; end
                if (tx_trn_data_ready) begin
                    rx_q.push_back(tx_trn_data);
                    if (tx_trn_data_last) begin rx_last_idx = rx_q.size() - 1; break; end
                end
            end else if (rx_q.size() > 0) begin
                rx_bubbles++;
            end
            @(negedge clk);
            if (++cyc > 4 * MPS) begin rx_timeout = 1; break; end
        end
        if (!rx_timeout) @(negedge clk);
        tx_trn_data_ready = 1'b0;
    endtask

    task automatic send_ack(input bit clr);
        @(negedge clk);
        rx_trn_hsk_received = 1'b1; rx_trn_hsk_type = 2'b00; toggle_clear = clr;
        @(negedge clk);
        rx_trn_hsk_received = 1'b0; toggle_clear = 1'b0;
        m_toggle = clr ? 1'b0 : ~m_toggle;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || ep_busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle: tready=%0b busy=%0b, want 0 0", s_axis_tready, ep_busy);
        end
        checks++;
        if ({tx_trn_send_hsk, tx_trn_hsk_type, tx_trn_data_start, tx_trn_data_type, tx_trn_data, tx_trn_data_valid, tx_trn_data_last} !== 16'h0) begin
            failures++; $display("FAIL reset_tx: tx outputs nonzero (hsk=%0b start=%0b valid=%0b), want 0", tx_trn_send_hsk, tx_trn_data_start, tx_trn_data_valid);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++; $display("FAIL reset_release_tready: got %0b before first clock, want 0", s_axis_tready);
        end
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++; $display("FAIL reset_first_clock_tready: got %0b, want 1", s_axis_tready);
        end
    endtask

    task automatic test_basic();
        pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = pkt_q;
        push_packet(1'b1, 1'b0);
        checks++;
        if (s_axis_tready !== 1'b0 || ep_busy !== 1'b1) begin
            failures++; $display("FAIL basic_ready_state: tready=%0b busy=%0b, want 0 1", s_axis_tready, ep_busy);
        end
        in_receive(1'b0);
        checks++;
        if (rx_starts !== 1 || rx_pid !== 2'b00) begin
            failures++; $display("FAIL basic_start_pid: starts=%0d pid=%b, want 1 00", rx_starts, rx_pid);
        end
        checks++;
        if (data_errors() != 0 || rx_last_idx != 3) begin
            failures++; $display("FAIL basic_data: got %0d bytes last_idx=%0d, want 4 bytes last_idx=3", rx_q.size(), rx_last_idx);
        end
        send_ack(1'b0);
        checks++;
        if (ep_busy !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++; $display("FAIL basic_after_ack: busy=%0b tready=%0b, want 0 1", ep_busy, s_axis_tready);
        end
    endtask

    task automatic test_nak();
        int drops = 0;
        int hold = $urandom_range(1, 6);
        logic [7:0] part[$];
        send_token(2'b10, 4'd1);
        checks++;
        if (tx_trn_send_hsk !== 1'b1 || tx_trn_hsk_type !== 2'b10 || ep_busy !== 1'b0) begin
            failures++; $display("FAIL nak_empty: send_hsk=%0b type=%b busy=%0b, want 1 10 0", tx_trn_send_hsk, tx_trn_hsk_type, ep_busy);
        end
        repeat (hold) begin
            @(negedge clk);
            if (tx_trn_send_hsk !== 1'b1 || tx_trn_data_valid !== 1'b0) drops++;
        end
        checks++;
        if (drops != 0) begin
            failures++; $display("FAIL nak_hold: dropped in %0d of %0d cycles, want 0", drops, hold);
        end
        tx_trn_hsk_sended = 1'b1;
        @(negedge clk);
        tx_trn_hsk_sended = 1'b0;
        checks++;
        if (tx_trn_send_hsk !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++; $display("FAIL nak_release: send_hsk=%0b tready=%0b, want 0 1", tx_trn_send_hsk, s_axis_tready);
        end
        // NAK with a partial packet keeps the bytes already written.
        make_packet(4);
        part = exp_q;
        pkt_q = part[0:2];
        push_packet(1'b0, 1'b1);
        send_token(2'b10, 4'd1);
        checks++;
        if (tx_trn_send_hsk !== 1'b1 || ep_busy !== 1'b1) begin
            failures++; $display("FAIL nak_partial: send_hsk=%0b busy=%0b, want 1 1", tx_trn_send_hsk, ep_busy);
        end
        tx_trn_hsk_sended = 1'b1;
        @(negedge clk);
        tx_trn_hsk_sended = 1'b0;
        pkt_q = part[3:3];
        push_packet(1'b1, 1'b0);
        in_receive(1'b1);
        checks++;
        if (data_errors() != 0 || rx_pid !== exp_pid()) begin
            failures++; $display("FAIL nak_partial_data: %0d bytes pid=%b, want %0d bytes pid=%b", rx_q.size(), rx_pid, exp_q.size(), exp_pid());
        end
        send_ack(1'b0);
    endtask

    task automatic test_retry();
        logic [1:0] first_pid;
        make_packet($urandom_range(1, 40));
        push_packet(1'b1, 1'b1);
        in_receive(1'b1);
        first_pid = rx_pid;
        checks++;
        if (data_errors() != 0 || first_pid !== exp_pid()) begin
            failures++; $display("FAIL retry_first: %0d bytes pid=%b, want %0d bytes pid=%b", rx_q.size(), first_pid, exp_q.size(), exp_pid());
        end
        repeat (300) @(negedge clk);
        checks++;
        if (ep_busy !== 1'b1 || s_axis_tready !== 1'b0) begin
            failures++; $display("FAIL retry_held: busy=%0b tready=%0b, want 1 0", ep_busy, s_axis_tready);
        end
        in_receive(1'b0);
        checks++;
        if (data_errors() != 0 || rx_pid !== exp_pid() || rx_starts != 1) begin
            failures++; $display("FAIL retry_resend: %0d bytes pid=%b starts=%0d, want %0d bytes pid=%b starts=1", rx_q.size(), rx_pid, rx_starts, exp_q.size(), exp_pid());
        end
        send_ack(1'b0);
    endtask

    task automatic test_full();
        @(negedge clk); toggle_clear = 1'b1;
        @(negedge clk); toggle_clear = 1'b0;
        m_toggle = 1'b0;
        make_packet(MPS);
        push_packet(1'b0, 1'b1);
        checks++;
        if (s_axis_tready !== 1'b0 || ep_busy !== 1'b1) begin
            failures++; $display("FAIL full_ready: tready=%0b busy=%0b, want 0 1", s_axis_tready, ep_busy);
        end
        in_receive(1'b1);
        checks++;
        if (data_errors() != 0 || rx_last_idx != MPS - 1 || rx_bubbles != 0) begin
            failures++; $display("FAIL full_data: %0d bytes last_idx=%0d bubbles=%0d, want %0d bytes last_idx=%0d bubbles=0", rx_q.size(), rx_last_idx, rx_bubbles, MPS, MPS - 1);
        end
        checks++;
        if (rx_pid !== 2'b00) begin
            failures++; $display("FAIL full_pid: got %b, want 00", rx_pid);
        end
        send_ack(1'b0);
        make_packet(2);
        push_packet(1'b1, 1'b0);
        in_receive(1'b0);
        checks++;
        if (rx_pid !== 2'b10 || data_errors() != 0) begin
            failures++; $display("FAIL full_second_pid: pid=%b %0d bytes, want 10 2 bytes", rx_pid, rx_q.size());
        end
        send_ack(1'b0);
    endtask

    task automatic test_ignore();
        logic [1:0] tt[4] = '{2'b10, 2'b00, 2'b11, 2'b10};
        logic [3:0] te[4] = '{4'd2, 4'd1, 4'd1, 4'd15};
        make_packet($urandom_range(5, 30));
        push_packet(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            int bad = 0;
            send_token(tt[k], te[k]);
            repeat (6) begin
                if (tx_trn_send_hsk || tx_trn_data_valid || ep_busy !== 1'b1 || s_axis_tready !== 1'b0) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                failures++; $display("FAIL ignore_token type=%b ep=%0d: reacted in %0d cycles, want 0", tt[k], te[k], bad);
            end
        end
        in_receive(1'b1);
        checks++;
        if (data_errors() != 0 || rx_pid !== exp_pid()) begin
            failures++; $display("FAIL ignore_data: %0d bytes pid=%b, want %0d bytes pid=%b", rx_q.size(), rx_pid, exp_q.size(), exp_pid());
        end
        send_ack(1'b1);
        make_packet(3);
        push_packet(1'b1, 1'b0);
        in_receive(1'b0);
        checks++;
        if (rx_pid !== 2'b00 || data_errors() != 0) begin
            failures++; $display("FAIL clear_wins_over_ack: pid=%b, want 00", rx_pid);
        end
        send_ack(1'b0);
    endtask

    task automatic test_reset_mid_send();
        make_packet(30);
        push_packet(1'b1, 1'b0);
        send_token(2'b10, 4'd1);
        checks++;
        if (tx_trn_data_start !== 1'b1 || tx_trn_data_type !== exp_pid()) begin
            failures++; $display("FAIL midsend_start: start=%0b type=%b, want 1 %b", tx_trn_data_start, tx_trn_data_type, exp_pid());
        end
        tx_trn_data_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_trn_data_valid !== 1'b0 || tx_trn_data_start !== 1'b0 || tx_trn_send_hsk !== 1'b0 || s_axis_tready !== 1'b0 || ep_busy !== 1'b0) begin
            failures++; $display("FAIL midsend_reset: valid=%0b hsk=%0b tready=%0b busy=%0b, want 0 0 0 0", tx_trn_data_valid, tx_trn_send_hsk, s_axis_tready, ep_busy);
        end
        tx_trn_data_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_toggle = 1'b0;
        @(negedge clk);
        make_packet($urandom_range(1, 16));
        push_packet(1'b1, 1'b1);
        in_receive(1'b1);
        checks++;
        if (rx_pid !== 2'b00 || data_errors() != 0) begin
            failures++; $display("FAIL midsend_after: pid=%b %0d bytes, want 00 %0d bytes", rx_pid, rx_q.size(), exp_q.size());
        end
        send_ack(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            bit clr;
            make_packet($urandom_range(1, 64));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); toggle_clear = 1'b1;
                @(negedge clk); toggle_clear = 1'b0;
                m_toggle = 1'b0;
            end
            push_packet(1'b1, 1'b1);
            in_receive(1'b1);
            checks++;
            if (data_errors() != 0 || rx_pid !== exp_pid() || rx_starts != 1 || rx_last_idx != exp_q.size() - 1) begin
                failures++; $display("FAIL b2b_pkt%0d: %0d bytes pid=%b starts=%0d last=%0d, want %0d bytes pid=%b starts=1", p, rx_q.size(), rx_pid, rx_starts, rx_last_idx, exp_q.size(), exp_pid());
            end
            clr = ($urandom_range(0, 3) == 0);
            send_ack(clr);
            checks++;
            if (ep_busy !== 1'b0) begin
                failures++; $display("FAIL b2b_busy%0d: got %0b after ACK, want 0", p, ep_busy);
            end
        end
    endtask

`ifdef USB_EP_HALT_EN
    task automatic test_halt();
        make_packet(8);
        push_packet(1'b1, 1'b0);
        ep_halt = 1'b1;
        send_token(2'b10, 4'd1);
        checks++;
        if (tx_trn_send_hsk !== 1'b1 || tx_trn_hsk_type !== 2'b11 || tx_trn_data_valid !== 1'b0) begin
            failures++; $display("FAIL halt_stall: send_hsk=%0b type=%b valid=%0b, want 1 11 0", tx_trn_send_hsk, tx_trn_hsk_type, tx_trn_data_valid);
        end
        tx_trn_hsk_sended = 1'b1;
        @(negedge clk);
        tx_trn_hsk_sended = 1'b0;
        checks++;
        if (tx_trn_send_hsk !== 1'b0 || ep_busy !== 1'b1) begin
            failures++; $display("FAIL halt_retained: send_hsk=%0b busy=%0b, want 0 1", tx_trn_send_hsk, ep_busy);
        end
        ep_halt = 1'b0;
        m_toggle = 1'b0;
        @(negedge clk);
        in_receive(1'b0);
        checks++;
        if (data_errors() != 0 || rx_pid !== 2'b00) begin
            failures++; $display("FAIL halt_resume: %0d bytes pid=%b, want 8 bytes pid=00", rx_q.size(), rx_pid);
        end
        send_ack(1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_nak();
        test_retry();
        test_full();
        test_ignore();
        test_reset_mid_send();
        test_back_to_back();
`ifdef USB_EP_HALT_EN
        test_halt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
